// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the MEM stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              valid_i;
    logic [3:0]        op_i;
    logic [DATA_W-1:0] src_a_i;
    logic [DATA_W-1:0] src_b_i;
    logic              flush_i;
    logic              ready_o;
    logic              done_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output valid_i, op_i, src_a_i, src_b_i, flush_i,
        input  ready_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  valid_i, op_i, src_a_i, src_b_i, flush_i,
        output ready_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO unit: MTHI/MTLO, fixed-latency multiply and radix-2 restoring divide committing to HI/LO.
// Define HILO_MADD_EN to implement MADD/MADDU/MSUB/MSUBU; otherwise those opcodes act as NOP.
//   state   | meaning
//   ST_IDLE | ready for a new op; MTHI/MTLO complete here
//   ST_MUL  | product latency countdown, commit when the counter hits zero
//   ST_DIV  | DATA_W restoring steps, then sign fix-up and commit
module hilo_muldiv_unit #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hilo_muldiv_unit_if.slave bus
);
    localparam logic [3:0] OP_MTHI  = 4'd1;
    localparam logic [3:0] OP_MTLO  = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PW      = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [PW-1:0]     r_mul_a;
    logic [PW-1:0]     r_mul_b;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvs;
    logic [DATA_W-1:0] r_dvd_raw;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;

    logic              w_accept;
    logic              w_mul_start;
    logic              w_div_start;
    logic              w_mul_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [PW-1:0]     w_prod;
    logic [PW-1:0]     w_mul_res;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_quo_fix;
    logic [DATA_W-1:0] w_rem_fix;

    assign w_accept     = bus.valid_i && !bus.flush_i && (r_state == ST_IDLE);
    assign w_div_start  = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU);
    assign w_mul_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_MADD) || (bus.op_i == OP_MSUB);
    assign w_a_neg      = (bus.op_i == OP_DIV) && bus.src_a_i[DATA_W-1];
    assign w_b_neg      = (bus.op_i == OP_DIV) && bus.src_b_i[DATA_W-1];

    // Operands are stored pre-extended to 2*DATA_W so one unsigned multiplier serves both signednesses.
    assign w_prod = r_mul_a * r_mul_b;

`ifdef HILO_MADD_EN
    typedef enum logic [1:0] {
        ACC_SET = 2'd0,
        ACC_ADD = 2'd1,
        ACC_SUB = 2'd2
    } acc_t;

    acc_t r_acc;
    acc_t w_acc_kind;

    assign w_mul_start = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU) ||
                         (bus.op_i == OP_MADD) || (bus.op_i == OP_MADDU) ||
                         (bus.op_i == OP_MSUB) || (bus.op_i == OP_MSUBU);

    always_comb begin
        w_acc_kind = ACC_SET;
        if ((bus.op_i == OP_MADD) || (bus.op_i == OP_MADDU)) begin
            w_acc_kind = ACC_ADD;
        end else if ((bus.op_i == OP_MSUB) || (bus.op_i == OP_MSUBU)) begin
            w_acc_kind = ACC_SUB;
        end
    end

    // Accumulation uses HI/LO as they stand at the commit edge.
    always_comb begin
        w_mul_res = w_prod;
        case (r_acc)
            ACC_ADD: w_mul_res = {r_hi, r_lo} + w_prod;
            ACC_SUB: w_mul_res = {r_hi, r_lo} - w_prod;
            default: w_mul_res = w_prod;
        endcase
    end
`else
    assign w_mul_start = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU);
    assign w_mul_res   = w_prod;
`endif

    assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    assign bus.ready_o = (r_state == ST_IDLE);
    assign bus.done_o  = r_done;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_dvd_raw <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
`ifdef HILO_MADD_EN
            r_acc     <= ACC_SET;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.op_i == OP_MTHI) begin
                            r_hi   <= bus.src_a_i;
                            r_done <= 1'b1;
                        end else if (bus.op_i == OP_MTLO) begin
                            r_lo   <= bus.src_a_i;
                            r_done <= 1'b1;
                        end else if (w_mul_start) begin
                            r_mul_a <= {{DATA_W{w_mul_signed & bus.src_a_i[DATA_W-1]}}, bus.src_a_i};
                            r_mul_b <= {{DATA_W{w_mul_signed & bus.src_b_i[DATA_W-1]}}, bus.src_b_i};
                            r_cnt   <= CNT_W'(MUL_LAT - 1);
                            r_state <= ST_MUL;
`ifdef HILO_MADD_EN
                            r_acc   <= w_acc_kind;
`endif
                        end else if (w_div_start) begin
                            r_quo     <= w_a_neg ? -bus.src_a_i : bus.src_a_i;
                            r_dvs     <= w_b_neg ? -bus.src_b_i : bus.src_b_i;
                            r_rem     <= '0;
                            r_dvd_raw <= bus.src_a_i;
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                            r_dz      <= (bus.src_b_i == '0);
                            r_cnt     <= CNT_W'(DATA_W);
                            r_state   <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (bus.flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_done       <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (bus.flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != '0) begin
                        // Borrow out of the trial subtraction means the divisor did not fit.
                        if (w_diff[DATA_W]) begin
                            r_rem <= w_rem_sh[DATA_W-1:0];
                            r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                        end else begin
                            r_rem <= w_diff[DATA_W-1:0];
                            r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                        end
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        if (r_dz) begin
                            r_lo <= '1;
                            r_hi <= r_dvd_raw;
                        end else begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed scenarios plus random ops against an arithmetic model.
module tb_hilo_muldiv_unit;
    localparam int DW       = 32;
    localparam int ML       = 2;
    localparam int MUL_DONE = ML + 1;
    localparam int DIV_DONE = DW + 2;

    logic clk = 1'b0;
    logic rst_i = 1'b0;

    hilo_muldiv_unit_if #(.DATA_W(DW)) bus ();

    hilo_muldiv_unit #(.DATA_W(DW), .MUL_LAT(ML)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] m_hi = '0;
    logic [DW-1:0] m_lo = '0;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the architectural HI/LO pair; returns done cycle (0 = none).
    task automatic model_apply(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               output int exp_k);
        logic [63:0] prod;
        logic [63:0] acc;
        longint sa, sb;
        exp_k = 0;
        prod  = '0;
        acc   = {m_hi, m_lo};
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        case (op)
            4'd1: begin m_hi = a; exp_k = 1; end
            4'd2: begin m_lo = a; exp_k = 1; end
            4'd3: begin prod = 64'(sa * sb); {m_hi, m_lo} = prod; exp_k = MUL_DONE; end
            4'd4: begin prod = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = prod; exp_k = MUL_DONE; end
            4'd5, 4'd6: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else if (op == 4'd5) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                exp_k = DIV_DONE;
            end
`ifdef HILO_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (op == 4'd7 || op == 4'd9) prod = 64'(sa * sb);
                else                          prod = {32'b0, a} * {32'b0, b};
                if (op == 4'd7 || op == 4'd8) {m_hi, m_lo} = acc + prod;
                else                          {m_hi, m_lo} = acc - prod;
                exp_k = MUL_DONE;
            end
`endif
            default: exp_k = 0;
        endcase
    endtask

    // Issues one op from a negedge with ready high; returns at the done negedge or after max_k cycles.
    task automatic do_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int max_k, output int done_k, output int rdy_low);
        bus.op_i    = op;
        bus.src_a_i = a;
        bus.src_b_i = b;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        done_k  = 0;
        rdy_low = 0;
        for (int k = 1; k <= max_k; k++) begin
            if (!bus.ready_o) rdy_low++;
            if (bus.done_o) begin
                done_k = k;
                break;
            end
            if (k < max_k) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = '0; bus.src_a_i = '0; bus.src_b_i = '0;
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi_o); end
        n_checks++; if (bus.lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.lo_o); end
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        rst_i = 1'b1;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        int ek, dk, rl;
        model_apply(4'd1, 32'h1234_5678, 32'h0, ek);
        do_op(4'd1, 32'h1234_5678, 32'h0, 45, dk, rl);
        n_checks++; if (dk !== 1) begin n_fail++; $display("FAIL mthi_done_cycle: got %0d want 1", dk); end
        n_checks++; if (bus.hi_o !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h want 12345678", bus.hi_o); end
        model_apply(4'd2, 32'h9ABC_DEF0, 32'h0, ek);
        do_op(4'd2, 32'h9ABC_DEF0, 32'h0, 45, dk, rl);
        n_checks++; if (dk !== 1) begin n_fail++; $display("FAIL mtlo_done_cycle: got %0d want 1", dk); end
        n_checks++; if (bus.lo_o !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mtlo_lo: got %h want 9abcdef0", bus.lo_o); end
        n_checks++; if (bus.hi_o !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want 12345678", bus.hi_o); end
        @(negedge clk);
        n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL mt_done_pulse_width: got %b want 0", bus.done_o); end
    endtask

    task automatic test_mul();
        int ek, dk, rl;
        model_apply(4'd3, 32'hFFFF_FFFD, 32'd5, ek);
        do_op(4'd3, 32'hFFFF_FFFD, 32'd5, 45, dk, rl);
        n_checks++; if (dk !== MUL_DONE) begin n_fail++; $display("FAIL mult_latency: got %0d want %0d", dk, MUL_DONE); end
        n_checks++; if (bus.hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi_o); end
        n_checks++; if (bus.lo_o !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h want fffffff1", bus.lo_o); end
        model_apply(4'd4, 32'hFFFF_FFFD, 32'd5, ek);
        do_op(4'd4, 32'hFFFF_FFFD, 32'd5, 45, dk, rl);
        n_checks++; if (dk !== MUL_DONE) begin n_fail++; $display("FAIL multu_latency: got %0d want %0d", dk, MUL_DONE); end
        n_checks++; if (bus.hi_o !== 32'h0000_0004) begin n_fail++; $display("FAIL multu_hi: got %h want 4", bus.hi_o); end
        n_checks++; if (bus.lo_o !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL multu_lo: got %h want fffffff1", bus.lo_o); end
    endtask

    task automatic test_div();
        int ek, dk, rl;
        model_apply(4'd5, 32'd7, 32'hFFFF_FFFE, ek);
        do_op(4'd5, 32'd7, 32'hFFFF_FFFE, 45, dk, rl);
        n_checks++; if (dk !== DIV_DONE) begin n_fail++; $display("FAIL div_latency: got %0d want %0d", dk, DIV_DONE); end
        n_checks++; if (rl !== DW + 1) begin n_fail++; $display("FAIL div_ready_low: got %0d want %0d", rl, DW + 1); end
        n_checks++; if (bus.lo_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", bus.lo_o); end
        n_checks++; if (bus.hi_o !== 32'h0000_0001) begin n_fail++; $display("FAIL div_hi: got %h want 1", bus.hi_o); end
        model_apply(4'd6, 32'd7, 32'd0, ek);
        do_op(4'd6, 32'd7, 32'd0, 45, dk, rl);
        n_checks++; if (dk !== DIV_DONE) begin n_fail++; $display("FAIL divu_zero_latency: got %0d want %0d", dk, DIV_DONE); end
        n_checks++; if (bus.lo_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h want ffffffff", bus.lo_o); end
        n_checks++; if (bus.hi_o !== 32'h0000_0007) begin n_fail++; $display("FAIL divu_zero_hi: got %h want 7", bus.hi_o); end
        model_apply(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, ek);
        do_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 45, dk, rl);
        n_checks++; if (bus.lo_o !== 32'h8000_0000) begin n_fail++; $display("FAIL div_minint_lo: got %h want 80000000", bus.lo_o); end
        n_checks++; if (bus.hi_o !== 32'h0) begin n_fail++; $display("FAIL div_minint_hi: got %h want 0", bus.hi_o); end
        model_apply(4'd5, 32'hFFFF_FFF9, 32'd0, ek);
        do_op(4'd5, 32'hFFFF_FFF9, 32'd0, 45, dk, rl);
        n_checks++; if (bus.hi_o !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL div_zero_signed_hi: got %h want fffffff9", bus.hi_o); end
    endtask

    task automatic test_busy_ignore();
        int ek, dk;
        model_apply(4'd5, 32'd100, 32'd7, ek);
        bus.op_i = 4'd5; bus.src_a_i = 32'd100; bus.src_b_i = 32'd7; bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        dk = 0;
        for (int k = 1; k <= 45; k++) begin
            if (bus.done_o) begin dk = k; break; end
            if (k == 5) begin bus.valid_i = 1'b1; bus.op_i = 4'd1; bus.src_a_i = 32'hDEAD_BEEF; end
            if (k == 6) bus.valid_i = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (dk !== DIV_DONE) begin n_fail++; $display("FAIL busy_div_latency: got %0d want %0d", dk, DIV_DONE); end
        n_checks++; if (bus.hi_o !== m_hi) begin n_fail++; $display("FAIL busy_mthi_ignored_hi: got %h want %h", bus.hi_o, m_hi); end
        n_checks++; if (bus.lo_o !== m_lo) begin n_fail++; $display("FAIL busy_div_lo: got %h want %h", bus.lo_o, m_lo); end
        repeat (3) @(negedge clk);
        n_checks++; if (bus.hi_o !== m_hi) begin n_fail++; $display("FAIL busy_not_queued_hi: got %h want %h", bus.hi_o, m_hi); end
    endtask

    task automatic test_flush();
        int ek, dk, rl, nd;
        // flush a divide at cycle 10
        bus.op_i = 4'd5; bus.src_a_i = 32'd1000; bus.src_b_i = 32'd3; bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_div_ready: got %b want 1", bus.ready_o); end
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done_o) nd++;
            @(negedge clk);
        end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL flush_div_no_done: got %0d pulses want 0", nd); end
        n_checks++; if (bus.hi_o !== m_hi) begin n_fail++; $display("FAIL flush_div_hi: got %h want %h", bus.hi_o, m_hi); end
        n_checks++; if (bus.lo_o !== m_lo) begin n_fail++; $display("FAIL flush_div_lo: got %h want %h", bus.lo_o, m_lo); end
        // flush with valid in IDLE blocks acceptance
        bus.op_i = 4'd2; bus.src_a_i = 32'h0000_0055; bus.valid_i = 1'b1; bus.flush_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0; bus.flush_i = 1'b0;
        n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_done: got %b want 0", bus.done_o); end
        n_checks++; if (bus.lo_o !== m_lo) begin n_fail++; $display("FAIL flush_idle_lo: got %h want %h", bus.lo_o, m_lo); end
        // flush a multiply one cycle after accept
        bus.op_i = 4'd3; bus.src_a_i = 32'd9; bus.src_b_i = 32'd9; bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0; bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_mul_ready: got %b want 1", bus.ready_o); end
        nd = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.done_o) nd++;
            @(negedge clk);
        end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL flush_mul_no_done: got %0d pulses want 0", nd); end
        n_checks++; if (bus.lo_o !== m_lo) begin n_fail++; $display("FAIL flush_mul_lo: got %h want %h", bus.lo_o, m_lo); end
        // flush during the done cycle leaves committed data alone
        model_apply(4'd1, 32'hA5A5_0F0F, 32'h0, ek);
        do_op(4'd1, 32'hA5A5_0F0F, 32'h0, 45, dk, rl);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        n_checks++; if (bus.hi_o !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL flush_done_cycle_hi: got %h want a5a50f0f", bus.hi_o); end
    endtask

    task automatic test_reset_mid_div();
        bus.op_i = 4'd5; bus.src_a_i = 32'd50; bus.src_b_i = 32'd5; bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        rst_i = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        n_checks++; if (bus.hi_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi: got %h want 0", bus.hi_o); end
        n_checks++; if (bus.lo_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo: got %h want 0", bus.lo_o); end
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", bus.ready_o); end
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_madd();
        int ek, dk, rl;
        model_apply(4'd1, 32'h0, 32'h0, ek);
        do_op(4'd1, 32'h0, 32'h0, 45, dk, rl);
        model_apply(4'd2, 32'h5, 32'h0, ek);
        do_op(4'd2, 32'h5, 32'h0, 45, dk, rl);
`ifdef HILO_MADD_EN
        model_apply(4'd7, 32'd2, 32'd3, ek);
        do_op(4'd7, 32'd2, 32'd3, 45, dk, rl);
        n_checks++; if (dk !== MUL_DONE) begin n_fail++; $display("FAIL madd_latency: got %0d want %0d", dk, MUL_DONE); end
        n_checks++; if (bus.lo_o !== 32'h0000_000B) begin n_fail++; $display("FAIL madd_lo: got %h want b", bus.lo_o); end
        n_checks++; if (bus.hi_o !== 32'h0) begin n_fail++; $display("FAIL madd_hi: got %h want 0", bus.hi_o); end
        model_apply(4'd10, 32'd1, 32'h0000_000C, ek);
        do_op(4'd10, 32'd1, 32'h0000_000C, 45, dk, rl);
        n_checks++; if (bus.hi_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL msubu_hi: got %h want ffffffff", bus.hi_o); end
        n_checks++; if (bus.lo_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL msubu_lo: got %h want ffffffff", bus.lo_o); end
`else
        do_op(4'd7, 32'd2, 32'd3, 3, dk, rl);
        n_checks++; if (dk !== 0) begin n_fail++; $display("FAIL madd_disabled_done: got %0d want 0", dk); end
        n_checks++; if (bus.lo_o !== 32'h5) begin n_fail++; $display("FAIL madd_disabled_lo: got %h want 5", bus.lo_o); end
        do_op(4'd10, 32'd1, 32'h0000_000C, 3, dk, rl);
        n_checks++; if (bus.hi_o !== 32'h0) begin n_fail++; $display("FAIL msubu_disabled_hi: got %h want 0", bus.hi_o); end
`endif
        do_op(4'd11, 32'h1111_1111, 32'h2222_2222, 3, dk, rl);
        n_checks++; if (dk !== 0) begin n_fail++; $display("FAIL undef_op_done: got %0d want 0", dk); end
        n_checks++; if (bus.lo_o !== m_lo) begin n_fail++; $display("FAIL undef_op_lo: got %h want %h", bus.lo_o, m_lo); end
        n_checks++; if (bus.hi_o !== m_hi) begin n_fail++; $display("FAIL undef_op_hi: got %h want %h", bus.hi_o, m_hi); end
    endtask

    task automatic test_random();
        int ek, dk, rl;
        logic [3:0]    op;
        logic [DW-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0)      b = '0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            else                                b = $urandom;
            if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = '1; end
            model_apply(op, a, b, ek);
            do_op(op, a, b, (ek == 0) ? 3 : 45, dk, rl);
            n_checks++; if (dk !== ek) begin n_fail++; $display("FAIL rand_done[%0d] op=%0d: got %0d want %0d", i, op, dk, ek); end
            n_checks++; if (bus.hi_o !== m_hi) begin n_fail++; $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, bus.hi_o, m_hi); end
            n_checks++; if (bus.lo_o !== m_lo) begin n_fail++; $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, bus.lo_o, m_lo); end
        end
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = '0; bus.src_a_i = '0; bus.src_b_i = '0;
        test_reset();
        test_mthi_mtlo();
        test_mul();
        test_div();
        test_busy_ignore();
        test_flush();
        test_reset_mid_div();
        test_madd();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
